spi_ram_arbiter: RTL

//   Shares the single spi_ram_controller between two requesters: port 0 (CPU fetch/data)
//   and port 1 (debug/loader). Latches one request and issues a one-cycle start pulse.

---
 rtl/spi_ram_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/spi_ram_arbiter.sv
// Two-port arbiter in front of spi_ram_controller; define SPI_ARB_ROUND_ROBIN_EN for round-robin ties (default: port 0 wins).
// Latency req->done is 4 cycles plus controller busy time; one transaction in flight, a waiting port simply holds req.
module spi_ram_arbiter #(
  parameter int ADDR_BITS        = 16,
  parameter int DATA_WIDTH_BYTES = 2,
  localparam int DW              = 8 * DATA_WIDTH_BYTES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p0_req,
  input  logic                 p0_we,
  input  logic [ADDR_BITS-1:0] p0_addr,
  input  logic [DW-1:0]        p0_wdata,
  output logic [DW-1:0]        p0_rdata,
  output logic                 p0_done,
  input  logic                 p1_req,
  input  logic                 p1_we,
  input  logic [ADDR_BITS-1:0] p1_addr,
  input  logic [DW-1:0]        p1_wdata,
  output logic [DW-1:0]        p1_rdata,
  output logic                 p1_done,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DW-1:0]        mem_wdata,
  output logic                 mem_start_read,
  output logic                 mem_start_write,
  input  logic [DW-1:0]        mem_rdata,
  input  logic                 mem_busy,
  output logic                 owner,
  output logic                 active
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   lat_we;
  logic [ADDR_BITS-1:0]   lat_addr;
  logic [DW-1:0]          lat_wdata;
  logic                   any_req;
  logic                   grant;
  logic                   take;

  assign any_req = p0_req | p1_req;
  assign take    = (state == S_IDLE) && any_req;

`ifdef SPI_ARB_ROUND_ROBIN_EN
  logic last_owner;

  always_comb begin
    grant = p1_req;
    if (p0_req && p1_req) grant = ~last_owner;
  end

  // Reset value 1 makes the very first tie go to port 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= 1'b1;
    end else if (take) begin
      last_owner <= grant;
    end
  end
`else
  assign grant = p1_req & ~p0_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      owner     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        owner     <= grant;
        lat_we    <= grant ? p1_we    : p0_we;
        lat_addr  <= grant ? p1_addr  : p0_addr;
        lat_wdata <= grant ? p1_wdata : p0_wdata;
      end
      // Read data is only trusted once busy has dropped; writes keep the old value.
      if (state == S_WAIT && !mem_busy && !lat_we) begin
        if (owner) p1_rdata <= mem_rdata;
        else       p0_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    mem_start_read  = 1'b0;
    mem_start_write = 1'b0;
    p0_done         = 1'b0;
    p1_done         = 1'b0;
    mem_addr        = lat_addr;
    mem_wdata       = lat_wdata;
    case (state)
      S_IDLE: begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (any_req) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        mem_start_write = lat_we;
        mem_start_read  = ~lat_we;
        state_nxt       = S_SETTLE;
      end
      // Controller busy is not yet meaningful in the cycle after a start.
      S_SETTLE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (!mem_busy) state_nxt = S_DONE;
      end
      S_DONE: begin
        p0_done   = ~owner;
        p1_done   = owner;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign active = (state != S_IDLE);

endmodule
